// File: rtl/reflet_align_bridge.sv
// Purpose: responder bridge from a Reflet data port to a word-only memory, splitting misaligned word accesses.
// Latency: aligned read 3, misaligned read 4, aligned write 2, misaligned write 6 cycles from acceptance to rsp_valid.
// Backpressure: one request outstanding; req_ready is high only in IDLE, and req_* are ignored otherwise.
module reflet_align_bridge #(
  parameter int wordsize   = 32,
  parameter int addr_width = 32,
  localparam int bytes     = wordsize / 8,
  localparam int off       = $clog2(bytes)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [addr_width-1:0]      req_addr,
  input  logic [wordsize-1:0]        req_wdata,
  output logic                       rsp_valid,
  output logic [wordsize-1:0]        rsp_rdata,
  output logic                       mem_en,
  output logic                       mem_write_en,
  output logic [addr_width-off-1:0]  mem_addr,
  output logic [wordsize-1:0]        mem_wdata,
  input  logic [wordsize-1:0]        mem_rdata
);

  localparam int WA = addr_width - off;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RLO,
    S_RHI,
    S_CAPLO,
    S_CAPHI,
    S_WLO,
    S_WHI,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WA-1:0]         r_word;
  logic [off-1:0]        r_off;
  logic                  r_write;
  logic [wordsize-1:0]   r_wdata;
  logic [wordsize-1:0]   r_lo;
  logic [wordsize-1:0]   r_hi;
  logic [wordsize-1:0]   r_rdata;

  logic [WA-1:0]         w_word_hi;
  logic                  w_aligned;
  logic [off+2:0]        w_shift;
  logic [2*wordsize-1:0] w_data_sh;
  logic [2*wordsize-1:0] w_mask_sh;
  logic [2*wordsize-1:0] w_merged;
  logic [wordsize-1:0]   w_rd_word;

  // The high word wraps modulo the word-address space; no error on overflow.
  assign w_word_hi = r_word + WA'(1);
  assign w_aligned = (r_off == '0);
  assign w_shift   = {r_off, 3'b000};

  // Little-endian merge: the write data slides up by the byte offset across the {hi,lo} pair,
  // replacing exactly `bytes` bytes and keeping the rest from the words read back.
  assign w_data_sh = {{wordsize{1'b0}}, r_wdata} << w_shift;
  assign w_mask_sh = {{wordsize{1'b0}}, {wordsize{1'b1}}} << w_shift;
  assign w_merged  = ({r_hi, r_lo} & ~w_mask_sh) | w_data_sh;

  // Misaligned read result, formed while the high word is on mem_rdata.
  assign w_rd_word = wordsize'({mem_rdata, r_lo} >> w_shift);

  assign rsp_rdata = r_rdata;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and memory strobe decode; memory outputs are zero unless a word op is active.
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mem_en       = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_write && (req_addr[off-1:0] == '0)) w_next = S_WLO;
          else                                        w_next = S_RLO;
        end
      end
      S_RLO: begin
        mem_en   = 1'b1;
        mem_addr = r_word;
        w_next   = (w_aligned && !r_write) ? S_CAPLO : S_RHI;
      end
      S_RHI: begin
        mem_en   = 1'b1;
        mem_addr = w_word_hi;
        w_next   = S_CAPHI;
      end
      S_CAPLO: begin
        w_next = S_RESP;
      end
      S_CAPHI: begin
        w_next = r_write ? S_WLO : S_RESP;
      end
      S_WLO: begin
        mem_en       = 1'b1;
        mem_write_en = 1'b1;
        mem_addr     = r_word;
        mem_wdata    = w_merged[wordsize-1:0];
        w_next       = w_aligned ? S_RESP : S_WHI;
      end
      S_WHI: begin
        mem_en       = 1'b1;
        mem_write_en = 1'b1;
        mem_addr     = w_word_hi;
        mem_wdata    = w_merged[2*wordsize-1:wordsize];
        w_next       = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latch and read-data capture; rsp_rdata only moves when a read completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word  <= '0;
      r_off   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_word  <= req_addr[addr_width-1:off];
            r_off   <= req_addr[off-1:0];
            r_write <= req_write;
            r_wdata <= req_wdata;
          end
        end
        S_RHI: begin
          r_lo <= mem_rdata;
        end
        S_CAPLO: begin
          r_lo    <= mem_rdata;
          r_rdata <= mem_rdata;
        end
        S_CAPHI: begin
          r_hi <= mem_rdata;
          if (!r_write) r_rdata <= w_rd_word;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_align_bridge.sv
// Scoreboard bench for reflet_align_bridge with a 1-cycle-latency word-array memory model.
module tb_reflet_align_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic        mem_write_en;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  reflet_align_bridge #(.wordsize(32), .addr_width(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // Memory model and operation log.
  typedef struct { logic wr; logic [29:0] a; } op_t;
  op_t ops[$];
  logic [31:0] mem [logic [29:0]];

  always @(posedge clk) begin
    if (mem_en) begin
      ops.push_back('{mem_write_en, mem_addr});
      if (mem_write_en) mem[mem_addr] = mem_wdata;
      else              mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // Scoreboard of expected responses.
  typedef struct { string nm; logic rd; logic [31:0] rdata; int acc; int lat; } exp_t;
  exp_t exq[$];

  always @(negedge clk) begin
    if (mem_write_en && !mem_en) fail("we_without_en");
    if (rsp_valid) begin
      if (exq.size() == 0) begin
        fail("unexpected_rsp");
      end else begin
        exp_t e;
        e = exq.pop_front();
        // This negedge lies in the cycle that ends with edge cyc+1.
        chk({e.nm, "_latency"}, 64'(cyc + 1 - e.acc), 64'(e.lat));
        if (e.rd) chk({e.nm, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
      end
    end
  end

  // Issue one request; lat==0 means no response is expected.
  task automatic send(input string nm, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic rd, input logic [31:0] rexp, input int lat, output int acc);
    int k;
    k = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) fail({nm, "_accept_timeout"});
    @(negedge clk);
    req_valid = 1'b0;
    acc = cyc;
    if (lat > 0) exq.push_back('{nm, rd, rexp, acc, lat});
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (exq.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (exq.size() != 0) begin
      fail({nm, "_rsp_timeout"});
      exq.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_ops(input string nm, input int n, input logic w0, input logic [29:0] a0,
                         input logic w1, input logic [29:0] a1);
    chk({nm, "_nops"}, 64'(ops.size()), 64'(n));
    if (n > 0 && ops.size() > 0) begin
      chk({nm, "_op0_wr"}, 64'(ops[0].wr), 64'(w0));
      chk({nm, "_op0_addr"}, 64'(ops[0].a), 64'(a0));
    end
    if (n > 1 && ops.size() > 1) begin
      chk({nm, "_op1_wr"}, 64'(ops[1].wr), 64'(w1));
      chk({nm, "_op1_addr"}, 64'(ops[1].a), 64'(a1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    mem[30'h100]      = 32'h03020100;
    mem[30'h101]      = 32'h07060504;
    mem[30'h3FFFFFFF] = 32'h11223344;
    mem[30'h0]        = 32'h55667788;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_write_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b1;

    // 1: aligned read
    ops.delete();
    send("t1_aligned_rd", 1'b0, 32'h400, 32'h0, 1'b1, 32'h03020100, 3, acc);
    wait_done("t1");
    chk_ops("t1", 1, 1'b0, 30'h100, 1'b0, 30'h0);

    // 2: misaligned read
    ops.delete();
    send("t2_misal_rd", 1'b0, 32'h401, 32'h0, 1'b1, 32'h04030201, 4, acc);
    wait_done("t2");
    chk_ops("t2", 2, 1'b0, 30'h100, 1'b0, 30'h101);

    // 3: misaligned write
    ops.delete();
    send("t3_misal_wr", 1'b1, 32'h402, 32'hAABBCCDD, 1'b0, 32'h0, 6, acc);
    wait_done("t3");
    chk("t3_nops", 64'(ops.size()), 64'd4);
    chk("t3_mem100", 64'(mem[30'h100]), 64'hCCDD0100);
    chk("t3_mem101", 64'(mem[30'h101]), 64'h0706AABB);

    // 4: aligned write, no reads
    ops.delete();
    send("t4_aligned_wr", 1'b1, 32'h404, 32'hDEADBEEF, 1'b0, 32'h0, 2, acc);
    wait_done("t4");
    chk_ops("t4", 1, 1'b1, 30'h101, 1'b0, 30'h0);
    chk("t4_mem101", 64'(mem[30'h101]), 64'hDEADBEEF);

    // 5: wrap-around misaligned read
    ops.delete();
    send("t5_wrap_rd", 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h66778811, 4, acc);
    wait_done("t5");
    chk_ops("t5", 2, 1'b0, 30'h3FFFFFFF, 1'b0, 30'h0);

    // 6: misaligned write aborted by reset during WHI
    ops.delete();
    send("t6_abort_wr", 1'b1, 32'h403, 32'h12345678, 1'b0, 32'h0, 0, acc);
    repeat (4) @(negedge clk);
    chk("t6_in_whi_we", 64'(mem_write_en), 64'd1);
    chk("t6_in_whi_addr", 64'(mem_addr), 64'h101);
    reset = 1'b0;
    #1;
    chk("t6_rst_req_ready", 64'(req_ready), 64'd1);
    chk("t6_rst_mem_en", 64'(mem_en), 64'd0);
    chk("t6_rst_mem_we", 64'(mem_write_en), 64'd0);
    chk("t6_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("t6_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("t6_nops", 64'(ops.size()), 64'd3);
    chk("t6_mem100", 64'(mem[30'h100]), 64'h78DD0100);
    chk("t6_mem101", 64'(mem[30'h101]), 64'hDEADBEEF);
    reset = 1'b1;

    ops.delete();
    send("t6_next_rd", 1'b0, 32'h400, 32'h0, 1'b1, 32'h78DD0100, 3, acc);
    wait_done("t6n");
    chk_ops("t6n", 1, 1'b0, 30'h100, 1'b0, 30'h0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
